// File: rtl/led_pkg.sv
// Shared types for the LED brightness path: sequencer states and the duty word type
// used between the sequencer and the PWM stage.
package led_pkg;

    localparam int LED_DUTY_W = 16;

    typedef logic [LED_DUTY_W-1:0] duty_t;

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        HOLD_HIGH,
        RAMP_DOWN,
        HOLD_LOW
    } seq_state_t;

endpackage

// File: rtl/led_tick_gen.sv
// Step pacing: free-running divider that emits a one-cycle tick every TICK_DIV cycles
// while enabled; held at zero when disabled.
module led_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!enable || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/led_duty_sequencer.sv
// Triangle-ramp duty sequencer for the LED PWM stage, one word per step tick over valid/ready.
// Optional square-law brightness correction when LED_GAMMA_EN is defined.
module led_duty_sequencer
    import led_pkg::*;
#(
    parameter int DUTY_W     = LED_DUTY_W,
    parameter int TICK_DIV   = 50000,
    parameter int STEP_SIZE  = 1024,
    parameter int HOLD_STEPS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_valid,
    input  logic              duty_ready,
    output logic              dir,
    output logic              overrun
);

    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;
    localparam logic [DUTY_W:0]   MAX_EXT  = {1'b0, DUTY_MAX};
    localparam logic [DUTY_W:0]   STEP_EXT = (DUTY_W + 1)'(STEP_SIZE);
    localparam int                HOLD_W   = $clog2(HOLD_STEPS + 2);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

    function automatic logic [DUTY_W-1:0] step_up(input logic [DUTY_W-1:0] lvl);
        logic [DUTY_W:0] sum;
        sum = {1'b0, lvl} + STEP_EXT;
        return (sum > MAX_EXT) ? DUTY_MAX : sum[DUTY_W-1:0];
    endfunction

    // Borrow out of the extra top bit means the subtraction went below zero.
    function automatic logic [DUTY_W-1:0] step_down(input logic [DUTY_W-1:0] lvl);
        logic [DUTY_W:0] diff;
        diff = {1'b0, lvl} - STEP_EXT;
        return diff[DUTY_W] ? '0 : diff[DUTY_W-1:0];
    endfunction

    function automatic logic [DUTY_W-1:0] shape(input logic [DUTY_W-1:0] lvl);
`ifdef LED_GAMMA_EN
        logic [2*DUTY_W-1:0] sq;
        sq = {{DUTY_W{1'b0}}, lvl} * {{DUTY_W{1'b0}}, lvl};
        return (lvl == DUTY_MAX) ? DUTY_MAX : sq[2*DUTY_W-1:DUTY_W];
`else
        return lvl;
`endif
    endfunction

    seq_state_t        state, state_n;
    logic [DUTY_W-1:0] level, level_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic              dir_n;
    logic              load;
    logic              tick;
    logic              busy;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    // A word accepted in this very cycle no longer blocks the tick.
    assign busy = duty_valid && !duty_ready;

    always_comb begin
        state_n = state;
        level_n = level;
        hold_n  = hold_cnt;
        dir_n   = dir;
        load    = 1'b0;
        if (tick && !busy) begin
            load = 1'b1;
            case (state)
                IDLE, RAMP_UP: begin
                    level_n = step_up(level);
                    dir_n   = 1'b1;
                    hold_n  = '0;
                    if (level_n == DUTY_MAX) begin
                        state_n = (HOLD_STEPS == 0) ? RAMP_DOWN : HOLD_HIGH;
                    end else begin
                        state_n = RAMP_UP;
                    end
                end
                HOLD_HIGH: begin
                    level_n = DUTY_MAX;
                    dir_n   = 1'b1;
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = RAMP_DOWN;
                        hold_n  = '0;
                    end else begin
                        hold_n = hold_cnt + HOLD_W'(1);
                    end
                end
                RAMP_DOWN: begin
                    level_n = step_down(level);
                    dir_n   = 1'b0;
                    hold_n  = '0;
                    if (level_n == '0) begin
                        state_n = (HOLD_STEPS == 0) ? RAMP_UP : HOLD_LOW;
                    end
                end
                HOLD_LOW: begin
                    level_n = '0;
                    dir_n   = 1'b0;
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = RAMP_UP;
                        hold_n  = '0;
                    end else begin
                        hold_n = hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    level_n = '0;
                    hold_n  = '0;
                end
            endcase
        end else if (!enable && !busy) begin
            state_n = IDLE;
            level_n = '0;
            hold_n  = '0;
            dir_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            level      <= '0;
            hold_cnt   <= '0;
            dir        <= 1'b0;
            duty       <= '0;
            duty_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state    <= state_n;
            level    <= level_n;
            hold_cnt <= hold_n;
            dir      <= dir_n;
            if (load) begin
                duty       <= shape(level_n);
                duty_valid <= 1'b1;
            end else if (duty_ready) begin
                duty_valid <= 1'b0;
            end
            if (tick && busy) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_duty_sequencer.sv
// Bench for led_duty_sequencer: cycle model of the triangle profile plus directed scenarios.
// Honours LED_GAMMA_EN for the expected duty values.
module tb_led_duty_sequencer;

    localparam int DUTY_W     = 16;
    localparam int TICK_DIV   = 4;
    localparam int STEP_SIZE  = 16384;
    localparam int HOLD_STEPS = 1;
    localparam int DMAX       = 65535;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              enable = 1'b0;
    logic              duty_ready = 1'b1;
    logic [DUTY_W-1:0] duty;
    logic              duty_valid;
    logic              dir;
    logic              overrun;

    int checks = 0;
    int errors = 0;

    led_duty_sequencer #(
        .DUTY_W(DUTY_W), .TICK_DIV(TICK_DIV), .STEP_SIZE(STEP_SIZE), .HOLD_STEPS(HOLD_STEPS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .duty       (duty),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .dir        (dir),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gam(input int lvl);
`ifdef LED_GAMMA_EN
        if (lvl == DMAX) return DMAX;
        return int'((longint'(lvl) * longint'(lvl)) >> 16);
`else
        return lvl;
`endif
    endfunction

    // One period of the profile, built from the ramp rules with plain arithmetic.
    int seq_duty[$];
    bit seq_dir[$];

    function automatic void build_seq();
        int v;
        v = 0;
        do begin
            v = (v + STEP_SIZE > DMAX) ? DMAX : v + STEP_SIZE;
            seq_duty.push_back(gam(v)); seq_dir.push_back(1'b1);
        end while (v < DMAX);
        for (int i = 0; i < HOLD_STEPS; i++) begin
            seq_duty.push_back(gam(DMAX)); seq_dir.push_back(1'b1);
        end
        do begin
            v = (v - STEP_SIZE < 0) ? 0 : v - STEP_SIZE;
            seq_duty.push_back(gam(v)); seq_dir.push_back(1'b0);
        end while (v > 0);
        for (int i = 0; i < HOLD_STEPS; i++) begin
            seq_duty.push_back(gam(0)); seq_dir.push_back(1'b0);
        end
    endfunction

    int m_cnt;
    int m_idx;
    bit m_valid;
    int m_duty;
    bit m_dir;
    bit m_over;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_idx <= 0; m_valid <= 1'b0; m_duty <= 0; m_dir <= 1'b0; m_over <= 1'b0;
        end else begin : mdl
            bit busy;
            bit tk;
            busy = m_valid && !duty_ready;
            tk   = enable && (m_cnt == TICK_DIV - 1);
            m_cnt <= enable ? (m_cnt + 1) % TICK_DIV : 0;
            if (tk && busy) m_over <= 1'b1;
            if (tk && !busy) begin
                m_duty  <= seq_duty[m_idx];
                m_dir   <= seq_dir[m_idx];
                m_idx   <= (m_idx + 1) % seq_duty.size();
                m_valid <= 1'b1;
            end else begin
                if (m_valid && duty_ready) m_valid <= 1'b0;
                if (!enable && !busy) begin
                    m_idx <= 0;
                    m_dir <= 1'b0;
                end
            end
        end
    end

    int acc_duty[$];
    bit acc_dir[$];

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_valid", duty_valid, m_valid);
            chk("model_duty", duty, m_duty);
            chk("model_dir", dir, m_dir);
            chk("model_overrun", overrun, m_over);
            if (duty_valid && duty_ready) begin
                acc_duty.push_back(duty);
                acc_dir.push_back(dir);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; duty_ready = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic wait_acc(input int n, input int budget);
        int c;
        c = 0;
        while (acc_duty.size() < n && c < budget) begin
            step(1);
            c++;
        end
        chk("accepted_count", acc_duty.size(), n);
    endtask

    int exp_lin[11] = '{16384, 32768, 49152, 65535, 65535, 49151, 32767, 16383, 0, 0, 16384};
    bit exp_dir[11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};

    initial begin
        int edges;
        build_seq();

        // reset state
        #1 rst_n = 1'b0;
        step(2);
        chk("rst_duty", duty, 0);
        chk("rst_valid", duty_valid, 0);
        chk("rst_dir", dir, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        step(1);

        // first word after enable, then a full profile period
        acc_duty.delete(); acc_dir.delete();
        enable = 1'b1; duty_ready = 1'b1;
        edges = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (duty_valid) begin
                edges = i;
                break;
            end
        end
        chk("first_valid_edge", edges, 4);
        chk("first_duty", duty, gam(16384));
        chk("first_dir", dir, 1);
        wait_acc(11, 60);
        if (acc_duty.size() >= 11) begin
`ifdef LED_GAMMA_EN
            chk("gamma_32768", acc_duty[1], 16384);
            chk("gamma_65535", acc_duty[3], 65535);
`else
            for (int i = 0; i < 11; i++) chk($sformatf("seq_duty[%0d]", i), acc_duty[i], exp_lin[i]);
`endif
            for (int i = 0; i < 11; i++) chk($sformatf("seq_dir[%0d]", i), acc_dir[i], exp_dir[i]);
        end

        // backpressure across a tick: overrun, stable word, nothing skipped
        do_reset();
        acc_duty.delete(); acc_dir.delete();
        enable = 1'b1; duty_ready = 1'b0;
        step(4);
        chk("bp_valid", duty_valid, 1);
        chk("bp_duty", duty, gam(16384));
        step(4);
        chk("bp_overrun", overrun, 1);
        chk("bp_duty_held", duty, gam(16384));
        chk("bp_valid_held", duty_valid, 1);
        step(2);
        duty_ready = 1'b1;
        wait_acc(2, 20);
        if (acc_duty.size() >= 2) begin
            chk("bp_acc0", acc_duty[0], gam(16384));
            chk("bp_acc1", acc_duty[1], gam(32768));
        end

        // accept in the same cycle as a tick
        do_reset();
        enable = 1'b1; duty_ready = 1'b0;
        step(7);
        chk("same_pending", duty_valid, 1);
        duty_ready = 1'b1;
        step(1);
        chk("same_overrun", overrun, 0);
        chk("same_valid", duty_valid, 1);
        chk("same_duty", duty, gam(32768));

        // enable drop with a pending word, then restart
        do_reset();
        enable = 1'b1; duty_ready = 1'b0;
        step(5);
        enable = 1'b0;
        step(3);
        chk("dis_valid_held", duty_valid, 1);
        chk("dis_duty_held", duty, gam(16384));
        duty_ready = 1'b1;
        step(1);
        chk("dis_valid_drop", duty_valid, 0);
        chk("dis_dir", dir, 0);
        chk("dis_duty_kept", duty, gam(16384));
        step(2);
        acc_duty.delete(); acc_dir.delete();
        enable = 1'b1;
        wait_acc(1, 20);
        if (acc_duty.size() >= 1) chk("restart_duty", acc_duty[0], gam(16384));

        // asynchronous reset while a word is pending
        do_reset();
        enable = 1'b1; duty_ready = 1'b0;
        step(9);
        chk("ar_pre_valid", duty_valid, 1);
        chk("ar_pre_overrun", overrun, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_valid", duty_valid, 0);
        chk("ar_duty", duty, 0);
        chk("ar_overrun", overrun, 0);
        chk("ar_dir", dir, 0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
